// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   CLKS_PER_BIT_DEF : default clk cycles per UART bit (115200 bps at system clk)
//   uart_state_e     : receiver FSM state encoding
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 1216;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_module_if.sv
// Serial-line and byte-output bundle of the UART receiver.
//   rxd       : raw asynchronous serial line (idle high)
//   rx_data   : last correctly framed byte
//   rx_flag   : one-cycle pulse when rx_data updates
//   frame_err : one-cycle pulse when the stop bit samples low
//   rx_busy   : receiver not idle
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_module_if;

    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data,
        output rx_flag,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data,
        input  rx_flag,
        input  frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk of latency)
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver, 8N1, LSB first.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   rx_if : master modport -- rxd in; rx_data, rx_flag, frame_err, rx_busy out
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit
//   HALF_BIT     : start-edge to mid-bit offset
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_rx_module_if.master   rx_if
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    rx_data;
    logic          rx_flag;
    logic          frame_err;
    logic          rxd_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_if.rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // Line back high at mid start bit: a glitch, drop it silently.
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            rx_data <= shreg;
                            rx_flag <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must not look like a new start bit.
                    cnt <= '0;
                    if (rxd_s) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = rx_data;
    assign rx_if.rx_flag   = rx_flag;
    assign rx_if.frame_err = frame_err;
    assign rx_if.rx_busy   = (state != IDLE);

endmodule

// File: doc/uart_rx_module.md
UART_RX_MODULE -- requirements
Module: uart_rx_module

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1216, meaning clk cycles per UART bit (115200 bps at the system clock).
REQ-002 SHALL provide parameter HALF_BIT, default CLKS_PER_BIT/2 (608), meaning the offset from the start-bit edge to the mid-bit sample.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_flag  output  1  one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer, both flops reset to 1; the FSM uses only the synchronized value rxd_s.
REQ-011 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 SHALL behave in IDLE as follows: when rxd_s=0, go to START with bit counter cnt=0; otherwise hold.
REQ-013 SHALL behave in START as follows: at cnt==HALF_BIT-1, if rxd_s=0, go to DATA with cnt=0 and bit index=0; if rxd_s=1, treat it as a glitch, return to IDLE, and pulse no output.
REQ-014 SHALL behave in DATA as follows: at cnt==CLKS_PER_BIT-1, shift rxd_s into shift register bit [index] (LSB first) and reset cnt=0; after index 7, go to STOP.
REQ-015 SHALL behave in STOP as follows: at cnt==CLKS_PER_BIT-1, if rxd_s=1, load rx_data from the shift register, pulse rx_flag for 1 cycle and go to IDLE; if rxd_s=0, pulse frame_err for 1 cycle, leave rx_data unchanged and go to WAIT_HIGH.
REQ-016 SHALL hold WAIT_HIGH until rxd_s=1, then go to IDLE, so that a break condition never retriggers a frame.
REQ-017 SHALL count cnt from 0 and clear it on every state transition; cnt width is clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1.
REQ-018 SHALL assert rx_flag, at default parameters, exactly HALF_BIT+9*CLKS_PER_BIT+2 cycles after the first clk edge at which raw rxd is sampled low.
REQ-019 SHALL never assert rx_flag and frame_err in the same cycle.
REQ-020 SHALL hold rx_data stable between rx_flag pulses; a consumer may sample it any time after the rx_flag rising edge, including after a 3-flop edge detector.
REQ-021 SHALL accept back-to-back frames with zero idle bits: the next start edge may be detected in IDLE on the cycle after rx_flag.
REQ-022 SHALL compute rx_busy combinationally from state, i.e. (state != IDLE).

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge, force state=IDLE, cnt=0, bit index=0, shift register=0x00, rx_data=0x00, rx_flag=0, frame_err=0, and synchronizer flops=1.
REQ-024 SHALL, on reset mid-frame, discard the partial byte with no rx_flag or frame_err pulse; after release, reception resumes at the next falling edge of rxd_s.

Structure
REQ-025 SHALL take the FSM state encoding and the default CLKS_PER_BIT value from shared package uart_pkg, which the transmitter also uses.
REQ-026 SHALL instantiate exactly one sub-module, uart_sync2 (the 2-flop synchronizer, parameterized reset value); all other logic stays in uart_rx_module.

Verification
REQ-027 SHALL cover nominal reception: frame 0xA5 at CLKS_PER_BIT=1216 -> rx_flag single pulse, rx_data=0xA5, frame_err=0.
REQ-028 SHALL cover glitch rejection: rxd low for 300 cycles, then high -> FSM returns to IDLE, no rx_flag, no frame_err.
REQ-029 SHALL cover framing error: frame 0x3C with stop bit low, then line high after 2 bit times -> frame_err pulse, rx_data keeps its previous value, FSM back in IDLE after the line rises.
REQ-030 SHALL cover back-to-back reception: frames 0x00, 0xFF, 0x55 with no idle gap -> three rx_flag pulses with matching rx_data values.
REQ-031 SHALL cover reset mid-frame: rst_n low for 1 cycle during data bit 4 of 0x81, then frame 0x42 -> no pulse for 0x81, rx_flag with rx_data=0x42.
REQ-032 SHALL cover baud tolerance: frames sent at ±2% bit period -> all bytes received correctly.
